// File: rtl/fifo_sc_param.sv
// Single-clock parametrised FIFO: arbitrary depth, standard or FWFT read, fill count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_sc_param #(
  parameter int unsigned W_DATA    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned W_CNT    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [W_DATA-1:0] data_in,
  input  logic              pop,
  output logic [W_DATA-1:0] data_out,
  output logic              valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [W_CNT-1:0]  count,
  input  logic              clr_err,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned W_PTR = $clog2(DEPTH);

  logic [W_DATA-1:0] mem_q [DEPTH];
  logic [W_PTR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [W_PTR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [W_CNT-1:0]  count_q, count_d;
  logic [W_DATA-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_ok, pop_ok;

  // Wrap by compare so non-power-of-2 depths work.
  function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
    return (p == W_PTR'(DEPTH - 1)) ? '0 : p + W_PTR'(1);
  endfunction

  assign full         = (count_q == W_CNT'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= W_CNT'(AF_THRESH));
  assign almost_empty = (count_q <= W_CNT'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    pop_ok      = pop & ~empty;
    push_ok     = push & (~full | pop_ok);
    wr_ptr_d    = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q + W_CNT'(push_ok) - W_CNT'(pop_ok);
    dout_d      = pop_ok ? mem_q[rd_ptr_q] : dout_q;
    valid_d     = pop_ok;
    // A fresh error in the clearing cycle keeps the flag set.
    overflow_d  = (overflow_q & ~clr_err) | (push & full & ~pop_ok);
    underflow_d = (underflow_q & ~clr_err) | (pop & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;
  assign valid    = (FWFT != 0) ? ~empty : valid_q;

endmodule

// File: tb/tb_fifo_sc_param.sv
// Directed bench for fifo_sc_param: three instances (depth 16 standard, depth 5 standard,
// depth 4 FWFT) with per-instance scoreboard queues of expected read data.
module tb_fifo_sc_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_push = 0, a_pop = 0, a_clr = 0;
  logic [7:0] a_din = 0, a_dout;
  logic       a_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_cnt;

  logic       b_push = 0, b_pop = 0, b_clr = 0;
  logic [7:0] b_din = 0, b_dout;
  logic       b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_cnt;

  logic       c_push = 0, c_pop = 0, c_clr = 0;
  logic [7:0] c_din = 0, c_dout;
  logic       c_valid, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [2:0] c_cnt;

  fifo_sc_param #(.W_DATA(8), .DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .push(a_push), .data_in(a_din), .pop(a_pop), .data_out(a_dout),
    .valid(a_valid), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_cnt), .clr_err(a_clr), .overflow(a_ovf),
    .underflow(a_unf)
  );

  fifo_sc_param #(.W_DATA(8), .DEPTH(5), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .push(b_push), .data_in(b_din), .pop(b_pop), .data_out(b_dout),
    .valid(b_valid), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_cnt), .clr_err(b_clr), .overflow(b_ovf),
    .underflow(b_unf)
  );

  fifo_sc_param #(.W_DATA(8), .DEPTH(4), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .push(c_push), .data_in(c_din), .pop(c_pop), .data_out(c_dout),
    .valid(c_valid), .full(c_full), .empty(c_empty), .almost_full(c_af),
    .almost_empty(c_ae), .count(c_cnt), .clr_err(c_clr), .overflow(c_ovf),
    .underflow(c_unf)
  );

  int n_pass = 0;
  int n_chk  = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];
  logic [7:0] exp_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_word(input string tag);
    chk({tag, "_valid"}, a_valid, 1);
    if (qa.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else chk({tag, "_data"}, a_dout, qa.pop_front());
  endtask

  initial begin
    #2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_count", a_cnt, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_ae", a_ae, 1);
    chk("rst_af", a_af, 0);
    chk("rst_flags", {a_ovf, a_unf}, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_c_valid", c_valid, 0);

    // Fill depth-16 FIFO with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      a_push = 1'b1;
      a_din  = 8'(i);
      qa.push_back(8'(i));
      tick();
      chk("fill_count", a_cnt, i);
      chk("fill_af", a_af, (i >= 14));
      chk("fill_full", a_full, (i == 16));
    end
    a_push = 1'b0;
    chk("fill_ae", a_ae, 0);

    // Drain with back-to-back pops; each word appears one cycle after its pop.
    for (int i = 1; i <= 16; i++) begin
      a_pop = 1'b1;
      tick();
      chk_a_word("drain");
      chk("drain_count", a_cnt, 16 - i);
    end
    a_pop = 1'b0;
    tick();
    chk("drain_valid_low", a_valid, 0);
    chk("drain_empty", a_empty, 1);
    chk("drain_dout_hold", a_dout, 8'h10);

    // Refill, then push+pop while full.
    for (int i = 1; i <= 16; i++) begin
      a_push = 1'b1;
      a_din  = 8'(8'h20 + i);
      qa.push_back(8'(8'h20 + i));
      tick();
    end
    chk("refill_full", a_full, 1);
    a_pop = 1'b1;
    a_din = 8'hAA;
    qa.push_back(8'hAA);
    tick();
    chk_a_word("full_pp");
    chk("full_pp_count", a_cnt, 16);
    chk("full_pp_ovf", a_ovf, 0);
    a_pop = 1'b0;
    a_din = 8'hBB;
    tick();
    a_push = 1'b0;
    chk("ovf_set", a_ovf, 1);
    chk("ovf_count", a_cnt, 16);
    chk("ovf_valid", a_valid, 0);
    for (int i = 1; i <= 16; i++) begin
      a_pop = 1'b1;
      tick();
      exp_d = (qa.size() == 1) ? 8'hAA : 8'h00;
      chk_a_word("full_drain");
      if (i == 16) chk("last_is_aa", a_dout, exp_d);
    end
    a_pop = 1'b0;
    tick();
    chk("full_drain_empty", a_empty, 1);

    // Error flag handling on the empty FIFO.
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("ovf_clr", a_ovf, 0);
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    chk("unf_set", a_unf, 1);
    chk("unf_valid", a_valid, 0);
    chk("unf_count", a_cnt, 0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("unf_clr", a_unf, 0);
    a_push = 1'b1;
    a_pop  = 1'b1;
    a_din  = 8'h77;
    qa.push_back(8'h77);
    tick();
    a_push = 1'b0;
    a_pop  = 1'b0;
    chk("empty_pp_count", a_cnt, 1);
    chk("empty_pp_unf", a_unf, 1);
    chk("empty_pp_valid", a_valid, 0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("unf_clr2", a_unf, 0);
    a_pop = 1'b1;
    tick();
    chk_a_word("pp_word");
    a_clr = 1'b1;
    tick();
    a_pop = 1'b0;
    a_clr = 1'b0;
    chk("clr_vs_err", a_unf, 1);

    // Depth 5: stream 12 words with count held at 2.
    for (int i = 0; i < 12; i++) begin
      b_push = 1'b1;
      b_pop  = (i >= 2);
      b_din  = 8'(8'hC0 + i);
      qb.push_back(8'(8'hC0 + i));
      tick();
      if (i >= 2) begin
        chk("b_stream_count", b_cnt, 2);
        chk("b_stream_valid", b_valid, 1);
        if (qb.size() == 0) chk("b_sb_empty", 1, 0);
        else chk("b_stream_data", b_dout, qb.pop_front());
      end
    end
    b_push = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("b_tail_valid", b_valid, 1);
      if (qb.size() == 0) chk("b_sb_empty", 1, 0);
      else chk("b_tail_data", b_dout, qb.pop_front());
    end
    b_pop = 1'b0;
    tick();
    chk("b_empty", b_empty, 1);
    chk("b_flags", {b_ovf, b_unf}, 0);

    // FWFT: data visible without a pop.
    c_push = 1'b1;
    c_din  = 8'h5A;
    qc.push_back(8'h5A);
    tick();
    c_push = 1'b0;
    chk("c_valid", c_valid, 1);
    chk("c_data", c_dout, qc[0]);
    c_pop = 1'b1;
    void'(qc.pop_front());
    tick();
    c_pop = 1'b0;
    chk("c_empty", c_empty, 1);
    chk("c_valid_low", c_valid, 0);
    for (int i = 0; i < 2; i++) begin
      c_push = 1'b1;
      c_din  = 8'(8'h11 * (i + 1));
      qc.push_back(8'(8'h11 * (i + 1)));
      tick();
    end
    c_push = 1'b0;
    chk("c_head", c_dout, qc[0]);
    c_pop = 1'b1;
    void'(qc.pop_front());
    tick();
    c_pop = 1'b0;
    chk("c_next", c_dout, qc[0]);
    chk("c_next_valid", c_valid, 1);

    // Mid-stream reset on depth 16 with count 7 (underflow still set).
    for (int i = 0; i < 7; i++) begin
      a_push = 1'b1;
      a_din  = 8'(8'h40 + i);
      tick();
    end
    a_push = 1'b0;
    chk("pre_rst_count", a_cnt, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    qa.delete();
    chk("mid_rst_count", a_cnt, 0);
    chk("mid_rst_empty", a_empty, 1);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_flags", {a_ovf, a_unf}, 0);
    a_push = 1'b1;
    a_din  = 8'h33;
    qa.push_back(8'h33);
    tick();
    a_push = 1'b0;
    a_pop  = 1'b1;
    tick();
    a_pop = 1'b0;
    chk_a_word("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
